// File: rtl/cam_uart_fifo.sv
// cam_uart_fifo: camera UART receiver (8N1) feeding a first-word fall-through
// byte FIFO. rclk is an asynchronous read strobe: one pop per rising edge.
// Sticky overflow/frame-error flags and JPEG end-of-image (FF D9) detection.
module cam_uart_fifo #(
   parameter int CLKS_PER_BIT = 1350,
   parameter int DEPTH        = 16,
   parameter int AF_THRESH    = 12,
   parameter int EOI_EN       = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      rx,
   input  logic                      rclk,
   input  logic                      clr,
   output logic [7:0]                rdata,
   output logic                      empty,
   output logic                      full,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      almost_full,
   output logic                      overflow,
   output logic                      frame_err,
   output logic                      jpeg_eoi
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP, S_RECOVER
   } rx_state_e;

   // synchronizer stages; stage 3 is only the previous value for edge detect
   logic rx_s1_q, rx_s2_q, rx_s3_q;
   logic rclk_s1_q, rclk_s2_q, rclk_s3_q;

   rx_state_e   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        rx_vld_q, rx_vld_d;     // shift_q holds a good byte this cycle
   logic        ferr_evt_q, ferr_evt_d; // stop bit was sampled low

   logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic        ovf_q, ovf_d, ferr_q, ferr_d;
   logic        ff_pend_q, ff_pend_d, eoi_q, eoi_d;
   logic [7:0]  mem_q [DEPTH];

   logic rx_fall, pop_req, pop_ok, push_ok, drop;

   assign rx_fall = rx_s3_q & ~rx_s2_q;
   assign pop_req = rclk_s2_q & ~rclk_s3_q;

   // two-flop synchronizers plus one history stage for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_s3_q   <= 1'b1;
         rclk_s1_q <= 1'b0;
         rclk_s2_q <= 1'b0;
         rclk_s3_q <= 1'b0;
      end else begin
         rx_s1_q   <= rx;
         rx_s2_q   <= rx_s1_q;
         rx_s3_q   <= rx_s2_q;
         rclk_s1_q <= rclk;
         rclk_s2_q <= rclk_s1_q;
         rclk_s3_q <= rclk_s2_q;
      end
   end

   // receiver next state: mid-bit sampling, LSB first, stop-bit validation
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      rx_vld_d   = 1'b0;
      ferr_evt_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rx_fall) begin
               state_d = S_START;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               state_d = rx_s2_q ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s2_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_s2_q) begin
                  rx_vld_d = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  ferr_evt_d = 1'b1;
                  state_d    = S_RECOVER;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_RECOVER: begin
            if (rx_s2_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // receiver state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         rx_vld_q   <= 1'b0;
         ferr_evt_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         rx_vld_q   <= rx_vld_d;
         ferr_evt_q <= ferr_evt_d;
      end
   end

   assign level       = wptr_q - rptr_q;
   assign empty       = (level == '0);
   assign full        = (level == (AW+1)'(DEPTH));
   assign almost_full = (level >= (AW+1)'(AF_THRESH));
   assign rdata       = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
   assign overflow    = ovf_q;
   assign frame_err   = ferr_q;
   assign jpeg_eoi    = eoi_q;

   // a pop frees a slot in the same cycle, so a full FIFO can still accept
   assign pop_ok  = pop_req & ~empty;
   assign push_ok = rx_vld_q & (~full | pop_ok);
   assign drop    = rx_vld_q & ~push_ok;

   // FIFO pointers, sticky flags and FF-D9 tracker; clr wins over everything
   always_comb begin
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      ovf_d     = ovf_q | drop;
      ferr_d    = ferr_q | ferr_evt_q;
      ff_pend_d = ff_pend_q;
      eoi_d     = (EOI_EN != 0) && rx_vld_q && ff_pend_q && (shift_q == 8'hD9);
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
      // tracker follows every good byte, dropped or not
      if (rx_vld_q)        ff_pend_d = (shift_q == 8'hFF);
      else if (ferr_evt_q) ff_pend_d = 1'b0;
      if (clr) begin
         wptr_d    = '0;
         rptr_d    = '0;
         ovf_d     = 1'b0;
         ferr_d    = 1'b0;
         ff_pend_d = 1'b0;
         eoi_d     = 1'b0;
      end
   end

   // FIFO control register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         ovf_q     <= 1'b0;
         ferr_q    <= 1'b0;
         ff_pend_q <= 1'b0;
         eoi_q     <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         ovf_q     <= ovf_d;
         ferr_q    <= ferr_d;
         ff_pend_q <= ff_pend_d;
         eoi_q     <= eoi_d;
      end
   end

   // byte storage; contents need no reset since empty masks rdata
   always_ff @(posedge clk) begin
      if (push_ok && !clr) mem_q[wptr_q[AW-1:0]] <= shift_q;
   end

endmodule

// File: tb/tb_cam_uart_fifo.sv
// Scoreboard bench for cam_uart_fifo: bytes are sent serially on rx, the
// expected FIFO contents are modelled in a queue and compared on each pop.
`timescale 1ns/1ps
module tb_cam_uart_fifo;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;
   localparam int AF    = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx = 1'b1;
   logic       rclk = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] rdata;
   logic       empty, full, almost_full, overflow, frame_err, jpeg_eoi;
   logic [2:0] level;

   cam_uart_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .AF_THRESH(AF), .EOI_EN(1)) dut (
      .clk(clk), .reset(reset), .rx(rx), .rclk(rclk), .clr(clr),
      .rdata(rdata), .empty(empty), .full(full), .level(level),
      .almost_full(almost_full), .overflow(overflow), .frame_err(frame_err),
      .jpeg_eoi(jpeg_eoi)
   );

   always #5 clk = ~clk;

   int         n_chk = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   logic       exp_ovf = 1'b0;
   logic       exp_ferr = 1'b0;
   int         eoi_cnt = 0;
   int         eoi_lvl = -1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // count cycles jpeg_eoi is high and remember the level seen with it
   always @(negedge clk) begin
      if (jpeg_eoi) begin
         eoi_cnt++;
         eoi_lvl = int'(level);
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] head();
      return (exp_q.size() > 0) ? exp_q[0] : 8'h00;
   endfunction

   // serial 8N1 frame; optionally pulse clr around the byte's push cycle
   task automatic send_byte(input logic [7:0] b, input logic stop_lvl, input bit clr_stop);
      @(negedge clk) rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_lvl;
      if (clr_stop) begin
         repeat (10) @(negedge clk);
         clr = 1'b1;
         repeat (3) @(negedge clk);
         clr = 1'b0;
         repeat (3) @(negedge clk);
      end else begin
         repeat (CPB) @(negedge clk);
      end
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
      if (clr_stop) begin
         exp_q.delete();
         exp_ovf  = 1'b0;
         exp_ferr = 1'b0;
      end else if (stop_lvl) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(b);
         else exp_ovf = 1'b1;
      end else begin
         exp_ferr = 1'b1;
      end
   endtask

   // one rclk pulse; level must move exactly on the third clk edge
   task automatic do_pop();
      int old_lvl;
      old_lvl = exp_q.size();
      chk("pop_head_before", rdata, head());
      @(negedge clk) rclk = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 chk("pop_not_early", level, old_lvl);
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      chk("pop_level", level, exp_q.size());
      chk("pop_head_after", rdata, head());
      chk("pop_empty", empty, exp_q.size() == 0);
      @(negedge clk) rclk = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_clr();
      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
      exp_q.delete();
      exp_ovf  = 1'b0;
      exp_ferr = 1'b0;
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_level"}, level, exp_q.size());
      chk({tag, "_empty"}, empty, exp_q.size() == 0);
      chk({tag, "_full"}, full, exp_q.size() == DEPTH);
      chk({tag, "_af"}, almost_full, exp_q.size() >= AF);
      chk({tag, "_rdata"}, rdata, head());
      chk({tag, "_ovf"}, overflow, exp_ovf);
      chk({tag, "_ferr"}, frame_err, exp_ferr);
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      chk_state("rst");
      chk("rst_eoi", jpeg_eoi, 1'b0);
      reset = 1'b1;
      repeat (5) @(negedge clk);

      // two bytes then a pop
      send_byte(8'h55, 1'b1, 1'b0);
      send_byte(8'hA3, 1'b1, 1'b0);
      chk_state("two");
      chk("two_head_const", rdata, 8'h55);
      do_pop();
      chk("one_head_const", rdata, 8'hA3);
      do_pop();

      // overflow: fifth byte dropped
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 1'b0);
      chk_state("ovf");
      chk("ovf_flag_const", overflow, 1'b1);
      for (int i = 0; i < 4; i++) do_pop();
      chk("ovf_drained", empty, 1'b1);
      do_clr();
      chk_state("clr1");

      // framing error then a good byte
      send_byte(8'h3C, 1'b0, 1'b0);
      chk_state("ferr");
      send_byte(8'h7E, 1'b1, 1'b0);
      chk_state("after_ferr");
      do_pop();
      do_clr();

      // EOI detection
      eoi_cnt = 0;
      send_byte(8'hFF, 1'b1, 1'b0);
      send_byte(8'hD9, 1'b1, 1'b0);
      chk("eoi_pulse", eoi_cnt, 1);
      chk("eoi_at_push", eoi_lvl, 2);
      do_pop();
      do_pop();
      eoi_cnt = 0;
      send_byte(8'hFF, 1'b1, 1'b0);
      send_byte(8'h00, 1'b1, 1'b0);
      send_byte(8'hD9, 1'b1, 1'b0);
      chk("eoi_broken", eoi_cnt, 0);
      for (int i = 0; i < 3; i++) do_pop();
      eoi_cnt = 0;
      send_byte(8'hFF, 1'b1, 1'b0);
      send_byte(8'hFF, 1'b1, 1'b0);
      send_byte(8'hD9, 1'b1, 1'b0);
      chk("eoi_ff_ff_d9", eoi_cnt, 1);
      for (int i = 0; i < 3; i++) do_pop();
      eoi_cnt = 0;
      send_byte(8'hFF, 1'b1, 1'b0);
      send_byte(8'h12, 1'b0, 1'b0);
      send_byte(8'hD9, 1'b1, 1'b0);
      chk("eoi_ferr_clears", eoi_cnt, 0);
      do_clr();

      // start-bit glitch and pop on empty
      @(negedge clk) rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      chk_state("glitch");
      do_pop();

      // reset in the middle of a frame
      @(negedge clk) rx = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      reset = 1'b0;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (12 * CPB) @(negedge clk);
      chk_state("midrst");
      send_byte(8'h5A, 1'b1, 1'b0);
      chk_state("after_midrst");
      do_pop();

      // clr during a byte's push with FIFO at 3 and overflow set
      for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i), 1'b1, 1'b0);
      do_pop();
      chk_state("pre_clr");
      send_byte(8'h99, 1'b1, 1'b1);
      chk_state("clr_push");
      send_byte(8'h42, 1'b1, 1'b0);
      chk_state("post_clr");
      do_pop();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
